// File: rtl/light_pkg.sv
// Shared constants for the rotating-LED chaser.
package light_pkg;

  localparam int unsigned LED_W                = 16;
  localparam logic [31:0] LIGHT_PERIOD_DEFAULT = 32'd5000000;
  localparam logic [15:0] LED_RESET            = 16'h0001;

endpackage

// File: rtl/light_tick.sv
// Free-running prescaler; tick is high whenever the count sits at zero.
module light_tick
  import light_pkg::*;
#(
  parameter logic [31:0] PERIOD = LIGHT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [31:0] r_count;
  logic [31:0] w_count_next;

  // >= rather than == so any out-of-range value recovers in one cycle
  always_comb begin
    w_count_next = r_count + 32'd1;
    if (r_count >= PERIOD) begin
      w_count_next = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 32'd0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign tick = (r_count == 32'd0);

endmodule

// File: rtl/light_chaser.sv
// Single hot bit rotating toward the MSB once every PERIOD+1 cycles.
module light_chaser
  import light_pkg::*;
#(
  parameter int unsigned WIDTH  = LED_W,
  parameter logic [31:0] PERIOD = LIGHT_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] led
);

  logic             w_tick;
  logic [WIDTH-1:0] r_led;

  light_tick #(
    .PERIOD(PERIOD)
  ) u_light_tick (
    .clk (clk),
    .rst (rst),
    .tick(w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else if (w_tick) begin
      r_led <= {r_led[WIDTH-2:0], r_led[WIDTH-1]};
    end
  end

  assign led = r_led;

endmodule

// File: tb/tb_light_chaser.sv
// Directed bench for light_chaser with PERIOD = 4 (rotation every 5 edges).
module tb_light_chaser;
  import light_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] led;

  int unsigned n_checks;
  int unsigned n_errors;

  light_chaser #(
    .WIDTH (16),
    .PERIOD(32'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle just after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rotl(input logic [15:0] v);
    return {v[14:0], v[15]};
  endfunction

  initial begin
    logic [15:0] prev;
    logic [15:0] seen;
    logic [15:0] exp;
    int          e;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;

    // 1: reset held for three edges
    step(1);
    check("reset_e1", 32'(led), 32'(LED_RESET));
    step(1);
    check("reset_e2", 32'(led), 32'h0001);
    step(1);
    check("reset_e3", 32'(led), 32'h0001);

    // 2: release, first edge rotates, then every 5 edges
    rst = 1'b0;
    step(1);
    check("first_rot", 32'(led), 32'h0002);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("hold_0002", 32'(led), 32'h0002);
    end
    step(1);
    check("second_rot", 32'(led), 32'h0004);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("hold_0004", 32'(led), 32'h0004);
    end
    step(1);
    check("third_rot", 32'(led), 32'h0008);

    // 3: sixteen full rotations, visiting every bit and wrapping
    seen = 16'h0008;
    exp  = 16'h0008;
    for (int r = 0; r < 16; r++) begin
      prev = led;
      for (int i = 0; i < 4; i++) begin
        step(1);
        check("rot_hold", 32'(led), 32'(prev));
      end
      step(1);
      exp = 16'h0001 << ((4 + r) % 16);
      check("rot_seq", 32'(led), 32'(exp));
      seen = seen | led;
      if (r == 12) check("wrap_to_0001", 32'(led), 32'h0001);
      if (r == 13) check("wrap_to_0002", 32'(led), 32'h0002);
    end
    check("all_bits_seen", 32'(seen), 32'hFFFF);

    // 4: reset on the 3rd edge of a period while led = 0x0010
    step(5);
    check("pre_mid_rst", 32'(led), 32'h0010);
    step(1);
    rst = 1'b1;
    step(1);
    check("mid_rst", 32'(led), 32'h0001);
    rst = 1'b0;
    step(1);
    check("mid_rst_rel", 32'(led), 32'h0002);
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("mid_rst_hold", 32'(led), 32'h0002);
    end
    step(1);
    check("mid_rst_restart", 32'(led), 32'h0004);

    // 5: reset coincides with the edge that would rotate
    step(4);
    check("pre_tick_rst", 32'(led), 32'h0004);
    rst = 1'b1;
    step(1);
    check("tick_rst_wins", 32'(led), 32'h0001);
    rst = 1'b0;
    step(1);
    check("tick_rst_rel", 32'(led), 32'h0002);

    // 6: 200 edges, one-hot always, change only on tick edges
    e = 1;
    for (int i = 0; i < 200; i++) begin
      prev = led;
      step(1);
      e++;
      check("onehot", 32'($countones(led)), 32'd1);
      if (((e - 1) % 5) == 0) check("tick_change", 32'(led), 32'(rotl(prev)));
      else                    check("no_change", 32'(led), 32'(prev));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
